// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache memory arbiter and the cache fill FSMs.
//   - state encoding of the arbiter FSM
//   - default main-memory read latency
//   - cache block size in words (the fill FSMs fetch one block per miss)
package cache_mem_arbiter_pkg;

    localparam int MEM_LATENCY_DEF = 4;
    localparam int BLOCK_WORDS     = 8;
    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;

    localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0] ST_WRITE_ENC  = 3'd1;
    localparam logic [2:0] ST_I_FILL_ENC = 3'd2;
    localparam logic [2:0] ST_D_FILL_ENC = 3'd3;
    localparam logic [2:0] ST_DRAIN_ENC  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_WRITE  = ST_WRITE_ENC,
        ST_I_FILL = ST_I_FILL_ENC,
        ST_D_FILL = ST_D_FILL_ENC,
        ST_DRAIN  = ST_DRAIN_ENC
    } arb_state_e;

    // Last fill owner, used for round-robin between the two caches.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/cache_mem_arbiter_outstanding_counter.sv
// Outstanding-read counter for the pipelined main memory.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : a read was issued this cycle
//   dec      : a read-data valid returned this cycle
//   count    : reads currently in flight
//   zero     : count == 0
// A valid arriving with nothing in flight is ignored (no underflow).
// An issue and a return in the same cycle leave the count unchanged.
module cache_mem_arbiter_outstanding_counter #(
    parameter int CNT_W     = 3,
    parameter int MAX_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic dec_ok;
    logic inc_ok;

    assign zero   = (count == '0);
    assign dec_ok = dec && !zero;
    // At the latency limit an issue is only legal together with a return,
    // so the count can never wrap.
    assign inc_ok = inc && ((count != CNT_W'(MAX_COUNT)) || dec_ok);

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc_ok && !dec_ok) begin
            count <= count + CNT_W'(1);
        end else if (dec_ok && !inc_ok) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Single-port arbiter in front of the shared pipelined main memory.
// Owners: I-cache fill FSM, D-cache fill FSM, D-cache write-through store.
//   clk, rst                    : clock, asynchronous active-high reset
//   i_miss, i_fill_busy, i_addr : I-cache fill request, busy, fill address
//   d_miss, d_fill_busy, d_addr : D-cache fill request, busy, fill address
//   d_wr_req, d_wr_addr/_data   : D-cache store request, address, data
//   mem_data_valid              : memory read-data valid
//   i_grant, d_grant            : fill ownership (registered decode of state)
//   i_data_valid, d_data_valid  : mem_data_valid routed to the fill owner
//   d_wr_done                   : store accepted this cycle
//   mem_enable, mem_wr          : memory access / write strobe
//   mem_addr, mem_wdata         : memory address / write data (0 when idle)
// Reads still in flight when a fill ends are drained and discarded before
// the memory is granted again, so no owner ever sees another owner's words.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int CNT_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic              i_fill_busy,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_miss,
    input  logic              d_fill_busy,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    input  logic              mem_data_valid,
    output logic              i_grant,
    output logic              d_grant,
    output logic              i_data_valid,
    output logic              d_data_valid,
    output logic              d_wr_done,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    arb_state_e       state;
    arb_state_e       state_next;
    owner_e           rr_last;
    owner_e           rr_next;
    logic             cnt_inc;
    logic             cnt_zero;
    logic [CNT_W-1:0] outstanding;
    logic             last_return;

    cache_mem_arbiter_outstanding_counter #(
        .CNT_W     (CNT_W),
        .MAX_COUNT (MEM_LATENCY)
    ) u_outstanding (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .dec   (mem_data_valid),
        .count (outstanding),
        .zero  (cnt_zero)
    );

    // The final in-flight word returns this cycle; leaving DRAIN now saves a cycle.
    assign last_return = mem_data_valid && (outstanding == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            rr_last <= OWN_D;
        end else begin
            state   <= state_next;
            rr_last <= rr_next;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // forgets an assignment would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        rr_next      = rr_last;
        i_grant      = 1'b0;
        d_grant      = 1'b0;
        i_data_valid = 1'b0;
        d_data_valid = 1'b0;
        d_wr_done    = 1'b0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        cnt_inc      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // Stores take priority; fills tie-break on the last fill owner.
                if (d_wr_req) begin
                    state_next = ST_WRITE;
                end else if (i_miss && (!d_miss || rr_last == OWN_D)) begin
                    state_next = ST_I_FILL;
                    rr_next    = OWN_I;
                end else if (d_miss) begin
                    state_next = ST_D_FILL;
                    rr_next    = OWN_D;
                end
            end

            ST_WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = d_wr_addr;
                mem_wdata  = d_wr_data;
                d_wr_done  = 1'b1;
                state_next = ST_IDLE;
            end

            ST_I_FILL: begin
                i_grant      = 1'b1;
                mem_enable   = i_fill_busy;
                mem_addr     = i_fill_busy ? i_addr : '0;
                cnt_inc      = i_fill_busy;
                i_data_valid = mem_data_valid && !cnt_zero;
                if (!i_fill_busy) begin
                    state_next = ST_DRAIN;
                end
            end

            ST_D_FILL: begin
                d_grant      = 1'b1;
                mem_enable   = d_fill_busy;
                mem_addr     = d_fill_busy ? d_addr : '0;
                cnt_inc      = d_fill_busy;
                d_data_valid = mem_data_valid && !cnt_zero;
                if (!d_fill_busy) begin
                    state_next = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (cnt_zero || last_return) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed testbench for cache_mem_arbiter. The bench models a pipelined
// memory with fixed read latency, the two fill FSMs (8-word blocks) and the
// store stage; expected cycle numbers are hand-computed from the state rules.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, i_fill_busy, d_miss, d_fill_busy, d_wr_req, mem_data_valid;
    logic [15:0] i_addr, d_addr, d_wr_addr, d_wr_data;
    logic        i_grant, d_grant, i_data_valid, d_data_valid, d_wr_done, mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_wdata;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.MEM_LATENCY(LAT), .CNT_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss         (i_miss),
        .i_fill_busy    (i_fill_busy),
        .i_addr         (i_addr),
        .d_miss         (d_miss),
        .d_fill_busy    (d_fill_busy),
        .d_addr         (d_addr),
        .d_wr_req       (d_wr_req),
        .d_wr_addr      (d_wr_addr),
        .d_wr_data      (d_wr_data),
        .mem_data_valid (mem_data_valid),
        .i_grant        (i_grant),
        .d_grant        (d_grant),
        .i_data_valid   (i_data_valid),
        .d_data_valid   (d_data_valid),
        .d_wr_done      (d_wr_done),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Environment model state
    int             cyc;
    logic [LAT-1:0] vpipe;
    bit             inject;
    int             i_fills_left, d_fills_left, i_words, d_words, i_issues, d_issues;
    bit             wr_pending;

    // Per-test observations
    int          n_i_dv, n_d_dv, n_wr_done, n_i_gcyc, n_drain, n_nonidle, n_cnt_nz;
    int          n_both, n_mdv, n_en;
    int          n_off_dirty = 0;
    int          i_rise[$], d_rise[$], done_cyc[$];
    logic [15:0] wr_addr_seen, wr_data_seen, first_i_addr;
    logic        wr_strobe_seen;
    bit          have_first_i, prev_i, prev_d;

    function automatic int q_at(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    task automatic clear_stats();
        n_i_dv = 0; n_d_dv = 0; n_wr_done = 0; n_i_gcyc = 0; n_drain = 0;
        n_nonidle = 0; n_cnt_nz = 0; n_both = 0; n_mdv = 0; n_en = 0;
        i_rise.delete(); d_rise.delete(); done_cyc.delete();
        wr_addr_seen = '0; wr_data_seen = '0; wr_strobe_seen = 1'b0;
        first_i_addr = '0; have_first_i = 0; prev_i = 0; prev_d = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_miss = 0; i_fill_busy = 0; i_addr = '0;
        d_miss = 0; d_fill_busy = 0; d_addr = '0;
        d_wr_req = 0; d_wr_addr = '0; d_wr_data = '0; mem_data_valid = 0;
        vpipe = '0; inject = 0; wr_pending = 0;
        i_fills_left = 0; d_fills_left = 0; i_words = 0; d_words = 0; i_issues = 0; d_issues = 0;
        clear_stats();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
    endtask

    // One clock cycle: drive memory/FSM inputs, sample at negedge, advance.
    // Entered and left 1 ns after a rising edge.
    task automatic step();
        logic issue;
        mem_data_valid = inject | vpipe[LAT-1];
        #1;
        i_fill_busy = i_grant && i_miss && ((i_words + (i_data_valid ? 1 : 0)) < BLOCK_WORDS);
        i_addr      = 16'h1230 + 16'(2 * (i_issues % BLOCK_WORDS));
        d_fill_busy = d_grant && d_miss && ((d_words + (d_data_valid ? 1 : 0)) < BLOCK_WORDS);
        d_addr      = 16'h5A00 + 16'(2 * (d_issues % BLOCK_WORDS));
        @(negedge clk);
        if (i_grant && !prev_i) i_rise.push_back(cyc);
        if (d_grant && !prev_d) d_rise.push_back(cyc);
        prev_i = i_grant;
        prev_d = d_grant;
        if (i_grant) n_i_gcyc++;
        if (i_data_valid) n_i_dv++;
        if (d_data_valid) n_d_dv++;
        if (d_wr_done) begin
            n_wr_done++;
            done_cyc.push_back(cyc);
            wr_addr_seen   = mem_addr;
            wr_data_seen   = mem_wdata;
            wr_strobe_seen = mem_wr && mem_enable;
        end
        if (dut.state == ST_DRAIN) n_drain++;
        if (dut.state != ST_IDLE) n_nonidle++;
        if (!dut.cnt_zero) n_cnt_nz++;
        if (i_grant && d_grant) n_both++;
        if (!mem_enable && (mem_addr != '0 || mem_wdata != '0)) n_off_dirty++;
        if (mem_data_valid) n_mdv++;
        if (mem_enable) n_en++;
        issue = mem_enable && !mem_wr;
        if (issue && i_grant && !have_first_i) begin
            have_first_i = 1;
            first_i_addr = mem_addr;
        end
        if (issue && i_grant) i_issues++;
        if (issue && d_grant) d_issues++;
        if (i_data_valid) i_words++;
        if (d_data_valid) d_words++;
        vpipe = {vpipe[LAT-2:0], issue};
        if (d_wr_done) wr_pending = 0;
        @(posedge clk);
        #1;
        cyc++;
        if (i_words == BLOCK_WORDS) begin
            i_words = 0; i_issues = 0;
            if (i_fills_left > 0) i_fills_left--;
        end
        if (d_words == BLOCK_WORDS) begin
            d_words = 0; d_issues = 0;
            if (d_fills_left > 0) d_fills_left--;
        end
        i_miss   = (i_fills_left > 0);
        d_miss   = (d_fills_left > 0);
        d_wr_req = wr_pending;
    endtask

    initial begin
        // 1: single I-cache fill, DRAIN of 3 speculative reads
        do_reset();
        check("reset_ctl", 32'({i_grant, d_grant, i_data_valid, d_data_valid, d_wr_done, mem_enable, mem_wr}), 32'd0);
        check("reset_bus", {mem_addr, mem_wdata}, 32'd0);
        check("reset_rr", 32'(dut.rr_last), 32'(OWN_D));
        check("reset_cnt_zero", 32'(dut.cnt_zero), 32'd1);
        i_fills_left = 1; i_miss = 1;
        repeat (22) step();
        check("t1_grant_cycle", q_at(i_rise, 0), 32'd1);
        check("t1_grant_count", i_rise.size(), 32'd1);
        check("t1_grant_len", n_i_gcyc, 32'd12);
        check("t1_first_addr", 32'(first_i_addr), 32'h1230);
        check("t1_i_dv", n_i_dv, 32'd8);
        check("t1_d_dv", n_d_dv, 32'd0);
        check("t1_mem_valids", n_mdv, 32'd11);
        check("t1_drain_len", n_drain, 32'd3);
        check("t1_end_idle", 32'(dut.state), 32'(ST_IDLE));
        check("t1_end_cnt_zero", 32'(dut.cnt_zero), 32'd1);

        // 2: tie after reset -> I, then D (re-tie, I was last), then I
        do_reset();
        i_fills_left = 2; i_miss = 1;
        d_fills_left = 1; d_miss = 1;
        repeat (50) step();
        check("t2_i_first", q_at(i_rise, 0), 32'd1);
        check("t2_d_after_drain", q_at(d_rise, 0), 32'd17);
        check("t2_i_second", q_at(i_rise, 1), 32'd33);
        check("t2_d_dv", n_d_dv, 32'd8);
        check("t2_i_dv", n_i_dv, 32'd16);
        check("t2_no_overlap", n_both, 32'd0);

        // 3: store and I miss together -> WRITE first
        do_reset();
        d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF; wr_pending = 1; d_wr_req = 1;
        i_fills_left = 1; i_miss = 1;
        repeat (20) step();
        check("t3_done_cycle", q_at(done_cyc, 0), 32'd1);
        check("t3_done_count", n_wr_done, 32'd1);
        check("t3_wr_addr", 32'(wr_addr_seen), 32'h0040);
        check("t3_wr_data", 32'(wr_data_seen), 32'hBEEF);
        check("t3_wr_strobe", 32'(wr_strobe_seen), 32'd1);
        check("t3_i_grant_cycle", q_at(i_rise, 0), 32'd3);

        // 4: store raised mid-fill waits for fill + drain
        do_reset();
        i_fills_left = 1; i_miss = 1;
        repeat (3) step();
        d_wr_addr = 16'h0A0A; d_wr_data = 16'h1234; wr_pending = 1; d_wr_req = 1;
        repeat (22) step();
        check("t4_done_cycle", q_at(done_cyc, 0), 32'd17);
        check("t4_done_count", n_wr_done, 32'd1);
        check("t4_wr_addr", 32'(wr_addr_seen), 32'h0A0A);
        check("t4_i_dv", n_i_dv, 32'd8);

        // 5: reset with 3 reads outstanding, then stray valids
        do_reset();
        i_fills_left = 1; i_miss = 1;
        repeat (4) step();
        check("t5_pre_outstanding", 32'(dut.outstanding), 32'd3);
        rst = 1'b1;
        i_fills_left = 0; i_miss = 0; i_words = 0; i_issues = 0;
        #1;
        check("t5_rst_ctl", 32'({i_grant, d_grant, i_data_valid, d_data_valid, d_wr_done, mem_enable, mem_wr}), 32'd0);
        check("t5_rst_bus", {mem_addr, mem_wdata}, 32'd0);
        check("t5_rst_cnt_zero", 32'(dut.cnt_zero), 32'd1);
        clear_stats();
        step();
        rst = 1'b0;
        repeat (8) step();
        check("t5_stray_valids", n_mdv, 32'd3);
        check("t5_i_dv", n_i_dv, 32'd0);
        check("t5_cnt_stays_zero", n_cnt_nz, 32'd0);
        check("t5_stays_idle", n_nonidle, 32'd0);

        // 6: valid in IDLE with nothing outstanding
        do_reset();
        inject = 1;
        repeat (3) step();
        inject = 0;
        repeat (3) step();
        check("t6_i_dv", n_i_dv, 32'd0);
        check("t6_d_dv", n_d_dv, 32'd0);
        check("t6_cnt_zero", n_cnt_nz, 32'd0);
        check("t6_idle", n_nonidle, 32'd0);
        check("t6_no_access", n_en, 32'd0);

        check("bus_zero_when_off", n_off_dirty, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
